// File: rtl/cc_miss_req_scheduler.sv
// Refill sequencer: turns cache miss requests into one AXI AR burst per line, pushes the
// miss address to the fill unit's FIFO, and merges misses to lines already being refilled.
module cc_miss_req_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int LINE_OFF_W      = 6,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshakes: a transfer happens in the cycle where valid & ready are both high.
    // Ready never depends on valid; AR valid, once raised, holds with stable address until ready.
    input  logic              miss_req_valid_i,
    input  logic [ADDR_W-1:0] miss_req_addr_i,
    output logic              miss_req_ready_o,
    output logic              miss_req_dup_o,
    output logic [ADDR_W-1:0] mem_araddr_o,
    output logic [3:0]        mem_arlen_o,
    output logic [2:0]        mem_arsize_o,
    output logic [1:0]        mem_arburst_o,
    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    input  logic              mem_rvalid_i,
    input  logic              mem_rready_i,
    input  logic              mem_rlast_i,
    input  logic              miss_addr_fifo_full_i,
    output logic              miss_addr_fifo_wren_o,
    output logic [ADDR_W-1:0] miss_addr_fifo_wdata_o,
    output logic [CNT_W-1:0]  outstanding_cnt_o,
    output logic              dbg_state_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int TAG_W = ADDR_W - LINE_OFF_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic   [CNT_W-1:0]          cnt;
    logic   [PTR_W-1:0]          wr_ptr;
    logic   [PTR_W-1:0]          rd_ptr;
    logic   [TAG_W-1:0]          tbl_tag   [MAX_OUTSTANDING];
    logic   [MAX_OUTSTANDING-1:0] tbl_valid;
    logic   [ADDR_W-1:0]         araddr_q;

    logic   [TAG_W-1:0]          req_tag;
    logic                        ready;
    logic                        accept;
    logic                        tag_hit;
    logic                        dup;
    logic                        accept_new;
    logic                        complete;

    assign req_tag = miss_req_addr_i[ADDR_W-1:LINE_OFF_W];

    // Valid bits still include an entry completing this cycle, so a miss to that line merges.
    always_comb begin
        tag_hit = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (tbl_valid[i] && (tbl_tag[i] == req_tag)) begin
                tag_hit = 1'b1;
            end
        end
    end

    assign ready      = (state == IDLE) && !miss_addr_fifo_full_i && (cnt < CNT_MAX);
    assign accept     = miss_req_valid_i && ready;
    assign dup        = accept && tag_hit;
    assign accept_new = accept && !tag_hit;
    // A stray rlast with nothing pending is dropped rather than underflowing the count.
    assign complete   = mem_rvalid_i && mem_rready_i && mem_rlast_i && (cnt != '0);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_new) state_nxt = ISSUE;
            ISSUE:   if (mem_arready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        miss_req_ready_o       = ready;
        miss_req_dup_o         = dup;
        miss_addr_fifo_wren_o  = accept_new;
        miss_addr_fifo_wdata_o = miss_req_addr_i;
        mem_arvalid_o          = (state == ISSUE);
        mem_araddr_o           = araddr_q;
        mem_arlen_o            = 4'd7;
        mem_arsize_o           = 3'b011;
        mem_arburst_o          = 2'b01;
        outstanding_cnt_o      = cnt;
        dbg_state_o            = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q <= '0;
        end else if (accept_new) begin
            araddr_q <= {req_tag, {LINE_OFF_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({accept_new, complete})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Pending-line table: in-order circular buffer; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tbl_valid <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tbl_tag[i] <= '0;
            end
        end else begin
            if (complete) begin
                tbl_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (accept_new) begin
                tbl_tag[wr_ptr]   <= req_tag;
                tbl_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
        end
    end

    a_no_rlast_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        (mem_rvalid_i && mem_rready_i && mem_rlast_i) |-> (cnt != '0)
    );

endmodule
